// File: rtl/dcm_reset_sequencer.sv
// rtl/dcm_reset_sequencer.sv - DCM reset/lock sequencer with timeout, retries and settle window (optional DCMSEQ_RELOCK_EN)
module dcm_reset_sequencer #(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 16,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       restart,
    input  logic       locked,
    output logic       dcm_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] relock_count
);

    // State code carries the outputs directly in bits [3:0] as
    // {dcm_reset, sys_reset, ready, fault}; bit 4 only separates SETTLE
    // from WAIT_LOCK. Outputs are therefore glitch-free register bits.
    typedef enum logic [4:0] {
        HOLD_RST  = 5'b0_1100,
        WAIT_LOCK = 5'b0_0100,
        SETTLE    = 5'b1_0100,
        RUN       = 5'b0_0010,
        FAULT     = 5'b0_1101
    } state_t;

    localparam logic [CNT_WIDTH-1:0] RST_LAST    = CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [3:0]           RETRY_LIMIT = 4'(MAX_RETRIES);

    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [3:0]             retry;
    logic                   locked_m;
    logic                   locked_s;

    assign dcm_reset   = state[3];
    assign sys_reset   = state[2];
    assign ready       = state[1];
    assign fault       = state[0];
    assign retry_count = retry;

    // Two-flop synchroniser for the asynchronous DCM lock indication
    always_ff @(posedge clock) begin
        if (reset) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    // Sequencer: hold RST, wait for lock with timeout/retry, settle, run
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            state <= HOLD_RST;
            cnt   <= '0;
            retry <= 4'd0;
        end else begin
            case (state)
                HOLD_RST: begin
                    if (cnt == RST_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt <= '0;
                        if (retry == RETRY_LIMIT) begin
                            state <= FAULT;
                        end else begin
                            retry <= retry + 4'd1;
                            state <= HOLD_RST;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    // Any glitch in lock restarts the timeout without costing a retry
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == SETTLE_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
`ifdef DCMSEQ_RELOCK_EN
                        state <= HOLD_RST;
                        cnt   <= '0;
                        retry <= 4'd0;
`else
                        state <= FAULT;
`endif
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= HOLD_RST;
                    cnt   <= '0;
                    retry <= 4'd0;
                end
            endcase
        end
    end

`ifdef DCMSEQ_RELOCK_EN
    logic [7:0] relock;

    // Count lock-loss recoveries from RUN, saturating; restart takes priority
    always_ff @(posedge clock) begin
        if (reset) begin
            relock <= 8'd0;
        end else if (!restart && state == RUN && !locked_s && relock != 8'hFF) begin
            relock <= relock + 8'd1;
        end
    end

    assign relock_count = relock;
`else
    assign relock_count = 8'd0;
`endif

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// tb/tb_dcm_reset_sequencer.sv - directed self-checking bench for dcm_reset_sequencer
module tb_dcm_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       restart = 1'b0;
    logic       locked = 1'b0;
    logic       dcm_reset;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] relock_count;

    int checks = 0;
    int errors = 0;

    dcm_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (10),
        .SETTLE_CYCLES(3),
        .MAX_RETRIES  (2),
        .CNT_WIDTH    (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .restart     (restart),
        .locked      (locked),
        .dcm_reset   (dcm_reset),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count),
        .relock_count(relock_count)
    );

    always #5 clock = ~clock;

    // Advance n clock periods; sampling and driving happen 1 time unit after the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Apply reset for one edge; returns positioned in period 0
    task automatic apply_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        locked = 1'b1;
        apply_reset();
        checks++;
        if ({dcm_reset, sys_reset, ready, fault} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outputs got %b want 1100", {dcm_reset, sys_reset, ready, fault});
        end
        checks++;
        if (retry_count !== 4'd0 || relock_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counts got retry=%0d relock=%0d want 0/0", retry_count, relock_count);
        end
    endtask

    task automatic test_lock_ok();
        locked = 1'b1;
        apply_reset();
        for (int n = 0; n <= 8; n++) begin
            logic [3:0] exp;
            if (n < 4)      exp = 4'b1100;
            else if (n < 8) exp = 4'b0100;
            else            exp = 4'b0010;
            checks++;
            if ({dcm_reset, sys_reset, ready, fault} !== exp) begin
                errors++;
                $display("FAIL lock_ok_p%0d got %b want %b", n, {dcm_reset, sys_reset, ready, fault}, exp);
            end
            if (n < 8) step(1);
        end
    endtask

    task automatic test_lock_fail();
        int highs = 0;
        locked = 1'b0;
        apply_reset();
        for (int n = 0; n <= 42; n++) begin
            if (n < 42 && dcm_reset) highs++;
            if (n == 13 || n == 14 || n == 28) begin
                logic [3:0] exp_r;
                exp_r = (n == 13) ? 4'd0 : (n == 14) ? 4'd1 : 4'd2;
                checks++;
                if (retry_count !== exp_r) begin
                    errors++;
                    $display("FAIL lock_fail_retry_p%0d got %0d want %0d", n, retry_count, exp_r);
                end
            end
            if (n == 41) begin
                checks++;
                if (fault !== 1'b0 || dcm_reset !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_fail_p41 got fault=%b dcm=%b want 0/0", fault, dcm_reset);
                end
            end
            if (n < 42) step(1);
        end
        checks++;
        if (highs !== 12) begin
            errors++;
            $display("FAIL lock_fail_dcm_high_periods got %0d want 12", highs);
        end
        checks++;
        if ({dcm_reset, sys_reset, ready, fault} !== 4'b1101 || retry_count !== 4'd2) begin
            errors++;
            $display("FAIL lock_fail_p42 got %b retry=%0d want 1101 retry=2",
                     {dcm_reset, sys_reset, ready, fault}, retry_count);
        end
        step(3);
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL lock_fail_absorb got fault=%b want 1", fault);
        end
    endtask

    // Called while in FAULT with locked low
    task automatic test_restart();
        restart = 1'b1;
        locked  = 1'b1;
        step(1);
        restart = 1'b0;
        checks++;
        if ({dcm_reset, sys_reset, ready, fault} !== 4'b1100 || retry_count !== 4'd0) begin
            errors++;
            $display("FAIL restart_hold got %b retry=%0d want 1100 retry=0",
                     {dcm_reset, sys_reset, ready, fault}, retry_count);
        end
        step(7);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL restart_ready_early got %b want 0", ready);
        end
        step(1);
        checks++;
        if (ready !== 1'b1 || sys_reset !== 1'b0) begin
            errors++;
            $display("FAIL restart_ready got ready=%b sys=%b want 1/0", ready, sys_reset);
        end
    endtask

    task automatic test_settle_glitch();
        locked = 1'b0;
        apply_reset();
        step(5);            // period 5
        locked = 1'b1;
        step(2);            // period 7
        locked = 1'b0;
        step(1);            // period 8
        locked = 1'b1;
        step(3);            // period 11
        checks++;
        if (ready !== 1'b0 || sys_reset !== 1'b1) begin
            errors++;
            $display("FAIL glitch_p11 got ready=%b sys=%b want 0/1", ready, sys_reset);
        end
        step(2);            // period 13
        checks++;
        if (ready !== 1'b0 || retry_count !== 4'd0) begin
            errors++;
            $display("FAIL glitch_p13 got ready=%b retry=%0d want 0/0", ready, retry_count);
        end
        step(1);            // period 14
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL glitch_p14 got ready=%b want 1", ready);
        end
    endtask

    task automatic test_relock();
        locked = 1'b1;
        apply_reset();
        step(9);            // period 9, RUN
        locked = 1'b0;
        step(1);            // period 10
        locked = 1'b1;
        step(1);            // period 11
        checks++;
        if (ready !== 1'b1 || sys_reset !== 1'b0) begin
            errors++;
            $display("FAIL relock_p11 got ready=%b sys=%b want 1/0", ready, sys_reset);
        end
        step(1);            // period 12
`ifdef DCMSEQ_RELOCK_EN
        checks++;
        if ({dcm_reset, sys_reset, ready, fault} !== 4'b1100 || relock_count !== 8'd1) begin
            errors++;
            $display("FAIL relock_p12 got %b relock=%0d want 1100 relock=1",
                     {dcm_reset, sys_reset, ready, fault}, relock_count);
        end
        step(3);            // period 15
        checks++;
        if (dcm_reset !== 1'b1) begin
            errors++;
            $display("FAIL relock_p15 got dcm=%b want 1", dcm_reset);
        end
        step(1);            // period 16
        checks++;
        if (dcm_reset !== 1'b0) begin
            errors++;
            $display("FAIL relock_p16 got dcm=%b want 0", dcm_reset);
        end
        step(3);            // period 19
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL relock_p19 got ready=%b want 0", ready);
        end
        step(1);            // period 20
        checks++;
        if (ready !== 1'b1 || relock_count !== 8'd1) begin
            errors++;
            $display("FAIL relock_p20 got ready=%b relock=%0d want 1/1", ready, relock_count);
        end
`else
        checks++;
        if ({dcm_reset, sys_reset, ready, fault} !== 4'b1101 || relock_count !== 8'd0) begin
            errors++;
            $display("FAIL lockloss_p12 got %b relock=%0d want 1101 relock=0",
                     {dcm_reset, sys_reset, ready, fault}, relock_count);
        end
        step(5);
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL lockloss_absorb got fault=%b want 1", fault);
        end
        // return to RUN for the following scenario
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(8);
`endif
    endtask

    task automatic test_back_to_back();
        // currently in RUN: reset wins over restart
        reset   = 1'b1;
        restart = 1'b1;
        step(1);
        reset   = 1'b0;
        restart = 1'b0;
        checks++;
        if ({dcm_reset, sys_reset, ready, fault} !== 4'b1100 || relock_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_restart got %b relock=%0d want 1100 relock=0",
                     {dcm_reset, sys_reset, ready, fault}, relock_count);
        end
        step(6);            // period 6, SETTLE
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if ({dcm_reset, sys_reset, ready, fault} !== 4'b1100) begin
            errors++;
            $display("FAIL settle_reset got %b want 1100", {dcm_reset, sys_reset, ready, fault});
        end
        step(3);            // period 3
        checks++;
        if (dcm_reset !== 1'b1) begin
            errors++;
            $display("FAIL settle_reset_p3 got dcm=%b want 1", dcm_reset);
        end
        step(1);            // period 4
        checks++;
        if (dcm_reset !== 1'b0 || sys_reset !== 1'b1) begin
            errors++;
            $display("FAIL settle_reset_p4 got dcm=%b sys=%b want 0/1", dcm_reset, sys_reset);
        end
        // restart during HOLD_RST restarts the hold count
        step(4);            // period 8, RUN
        restart = 1'b1;
        step(1);
        restart = 1'b0;     // hold period 0
        step(2);            // hold period 2
        restart = 1'b1;
        step(1);
        restart = 1'b0;     // hold period 0 again
        step(3);
        checks++;
        if (dcm_reset !== 1'b1) begin
            errors++;
            $display("FAIL hold_restart_p3 got dcm=%b want 1", dcm_reset);
        end
        step(1);
        checks++;
        if (dcm_reset !== 1'b0) begin
            errors++;
            $display("FAIL hold_restart_p4 got dcm=%b want 0", dcm_reset);
        end
    endtask

    initial begin
        step(2);
        test_reset();
        test_lock_ok();
        test_lock_fail();
        test_restart();
        test_settle_glitch();
        test_relock();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
